uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bus: bclk strobe and serial line in, assembled word and
// completion/error flags out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  bclk;
    logic                  rx;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rx_done;
    logic                  frame_err;

    // Line/strobe source side (transmitter environment, consumer of words).
    modport master (
        output bclk,
        output rx,
        input  dout,
        input  rx_done,
        input  frame_err
    );

    // Receiver side.
    modport slave (
        input  bclk,
        input  rx,
        output dout,
        output rx_done,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling of rx using the shared bclk strobe,
// mid-bit sampling, 1 start / DATA_WIDTH data (LSB first) / 1 stop, no parity.
// Emits a one-cycle rx_done with dout/frame_err for every completed frame.
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int OS_16_BCLK_CNT = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [3:0]        CNT_MID  = 4'(OS_16_BCLK_CNT / 2 - 1);
    localparam logic [3:0]        CNT_LAST = 4'(OS_16_BCLK_CNT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } state_t;

    state_t                state_q,     state_d;
    logic [3:0]            bclk_cnt_q,  bclk_cnt_d;
    logic [IDX_W-1:0]      bit_idx_q,   bit_idx_d;
    logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [DATA_WIDTH-1:0] dout_q,      dout_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rx_done_q,   rx_done_d;

    // Two-flop synchronizer; both flops idle high so reset never looks like a start bit.
    logic rx_meta_q;
    logic rx_s_q;

    // Bring the asynchronous serial line into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            bclk_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_cnt_q  <= bclk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            rx_done_q   <= rx_done_d;
        end
    end

    // Next-state logic: counters move only on bclk ticks, start detection runs every clk.
    always_comb begin
        state_d     = state_q;
        bclk_cnt_d  = bclk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        rx_done_d   = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    state_d    = RX_START;
                    bclk_cnt_d = '0;
                end
            end

            RX_START: begin
                if (bus.bclk) begin
                    if (bclk_cnt_q == CNT_MID) begin
                        // Mid start bit: a high line here means a glitch, not a frame.
                        if (!rx_s_q) begin
                            state_d    = RX_DATA;
                            bclk_cnt_d = '0;
                            bit_idx_d  = '0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        bclk_cnt_d = bclk_cnt_q + 4'd1;
                    end
                end
            end

            RX_DATA: begin
                if (bus.bclk) begin
                    if (bclk_cnt_q == CNT_LAST) begin
                        shreg_d[bit_idx_q] = rx_s_q;
                        bclk_cnt_d         = '0;
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = RX_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        bclk_cnt_d = bclk_cnt_q + 4'd1;
                    end
                end
            end

            RX_STOP: begin
                if (bus.bclk) begin
                    if (bclk_cnt_q == CNT_LAST) begin
                        // Word is reported even when the stop bit is bad.
                        dout_d      = shreg_q;
                        frame_err_d = ~rx_s_q;
                        rx_done_d   = 1'b1;
                        bclk_cnt_d  = '0;
                        // Leaving at mid stop bit keeps half a bit for the next start edge.
                        state_d     = rx_s_q ? RX_IDLE : RX_BREAK;
                    end else begin
                        bclk_cnt_d = bclk_cnt_q + 4'd1;
                    end
                end
            end

            RX_BREAK: begin
                // Wait out a held-low line so it yields only one errored frame.
                if (rx_s_q) begin
                    state_d = RX_IDLE;
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign bus.dout      = dout_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of frames plus hand-written sequences
// for glitch, break, back-to-back and mid-frame reset.
module tb_uart_rx;

    localparam int DW = 8;

    logic clk;
    logic rst;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(
        .DATA_WIDTH     (DW),
        .OS_16_BCLK_CNT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks;
    int errors;

    int unsigned tick_total = 0;

    typedef struct packed {
        logic [7:0]  d;
        logic        fe;
        logic [31:0] tk;
    } ev_t;

    ev_t log_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_dout;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bclk: one clk wide, every 4th clk, changed on the falling edge.
    initial begin
        bus.bclk = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.bclk = 1'b1;
            @(negedge clk);
            bus.bclk = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (bus.bclk === 1'b1) tick_total <= tick_total + 1;
    end

    always @(negedge clk) begin
        if (bus.rx_done === 1'b1) log_q.push_back(ev_t'{bus.dout, bus.frame_err, tick_total});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        while (bus.bclk !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one frame aligned to bclk; t0 is the tick count when the start bit falls.
    task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned t0);
        bus.rx = 1'b0;
        t0 = tick_total;
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            ticks(16);
        end
        bus.rx = stop;
        ticks(16);
    endtask

    task automatic check_event(input string nm, input int idx, input int unsigned t0,
                               input logic [7:0] ed, input logic efe);
        ev_t ev;
        if (log_q.size() > idx) begin
            ev = log_q[idx];
            chk({nm, " dout"}, 32'(ev.d), 32'(ed));
            chk({nm, " frame_err"}, 32'(ev.fe), 32'(efe));
            chk({nm, " latency"}, ev.tk - t0, 32'd152);
        end else begin
            chk({nm, " event present"}, 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int          n0;
        int unsigned t0;
        int unsigned t1;

        checks = 0;
        errors = 0;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 8'h81, 1'b1};
        vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 8'h01, 1'b0};

        // Reset with a toggling line.
        rst    = 1'b1;
        bus.rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.rx = ~bus.rx;
        end
        @(negedge clk);
        chk("reset dout", 32'(bus.dout), 32'h0);
        chk("reset rx_done", 32'(bus.rx_done), 32'h0);
        chk("reset frame_err", 32'(bus.frame_err), 32'h0);
        bus.rx = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(40);
        chk("post-reset no rx_done", 32'(log_q.size()), 32'd0);

        // Table of frames.
        for (int v = 0; v < 7; v++) begin
            n0 = log_q.size();
            send_frame(vecs[v].data, vecs[v].stop, t0);
            bus.rx = 1'b1;
            ticks(12);
            chk($sformatf("vec%0d count", v), 32'(log_q.size() - n0), 32'd1);
            check_event($sformatf("vec%0d", v), n0, t0, vecs[v].exp_dout, vecs[v].exp_fe);
        end

        // Glitch: 4 ticks low is rejected, next frame still works.
        n0 = log_q.size();
        bus.rx = 1'b0;
        ticks(4);
        bus.rx = 1'b1;
        ticks(20);
        chk("glitch no rx_done", 32'(log_q.size() - n0), 32'd0);
        send_frame(8'h3C, 1'b1, t0);
        ticks(12);
        chk("after glitch count", 32'(log_q.size() - n0), 32'd1);
        check_event("after glitch", n0, t0, 8'h3C, 1'b0);

        // Break: stop bit low then line held low.
        n0 = log_q.size();
        send_frame(8'h81, 1'b0, t0);
        ticks(40);
        chk("break count while low", 32'(log_q.size() - n0), 32'd1);
        check_event("break", n0, t0, 8'h81, 1'b1);
        bus.rx = 1'b1;
        ticks(12);
        chk("break count after release", 32'(log_q.size() - n0), 32'd1);
        n0 = log_q.size();
        send_frame(8'h55, 1'b1, t0);
        ticks(12);
        chk("after break count", 32'(log_q.size() - n0), 32'd1);
        check_event("after break", n0, t0, 8'h55, 1'b0);

        // Back-to-back frames, start bit right after stop bit.
        n0 = log_q.size();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        ticks(12);
        chk("b2b count", 32'(log_q.size() - n0), 32'd2);
        check_event("b2b first", n0, t0, 8'h00, 1'b0);
        check_event("b2b second", n0 + 1, t1, 8'hFF, 1'b0);

        // Reset in the middle of data bit 4 of 0x96.
        n0 = log_q.size();
        bus.rx = 1'b0;
        ticks(16);
        for (int i = 0; i < 4; i++) begin
            bus.rx = (8'h96 >> i) & 8'h01;
            ticks(16);
        end
        bus.rx = 1'b1;
        ticks(8);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset dout", 32'(bus.dout), 32'h0);
        chk("midreset frame_err", 32'(bus.frame_err), 32'h0);
        chk("midreset rx_done", 32'(bus.rx_done), 32'h0);
        ticks(3);
        rst = 1'b0;
        ticks(200);
        chk("midreset no rx_done", 32'(log_q.size() - n0), 32'd0);
        n0 = log_q.size();
        send_frame(8'h12, 1'b1, t0);
        ticks(12);
        chk("after midreset count", 32'(log_q.size() - n0), 32'd1);
        check_event("after midreset", n0, t0, 8'h12, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
